mod_counter_tff: RTL and testbench
==================================

MOD_COUNTER_TFF -- requirements
Module: mod_counter_tff

Interface
REQ-001 SHALL have parameter WIDTH, default 3, counter width in bits; legal range 1..16.
REQ-002 SHALL have parameter MODULUS, default 2**WIDTH, count sequence length; legal range 2..2**WIDTH.
REQ-003 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port clr  input  1  synchronous clear to 0.
REQ-006 SHALL have port load  input  1  synchronous parallel load of din.
REQ-007 SHALL have port din  input  WIDTH  load value.
REQ-008 SHALL have port en  input  1  count enable.
REQ-009 SHALL have port up  input  1  direction; 1 = increment, 0 = decrement.
REQ-010 SHALL have port q  output  WIDTH  current count, registered.
REQ-011 SHALL have port tc  output  1  terminal count, combinational.
REQ-012 SHALL have port wrap  output  1  registered one-cycle wrap pulse.
REQ-013 SHALL have port load_err  output  1  registered one-cycle out-of-range load pulse.

Function
REQ-014 SHALL evaluate controls each rising clock edge with priority clr > load > en; with none asserted, q holds.
REQ-015 SHALL, on clr, set q = 0, regardless of load, en and up.
REQ-016 SHALL, on load with din < MODULUS, set q = din on the next edge (1-cycle latency).
REQ-017 SHALL, on load with din >= MODULUS, set q = MODULUS-1 and pulse load_err high for exactly the following cycle.
REQ-018 SHALL, on en with up=1, set q = q+1, or 0 if q = MODULUS-1.
REQ-019 SHALL, on en with up=0, set q = q-1, or MODULUS-1 if q = 0.
REQ-020 SHALL drive tc = en AND ((up AND q = MODULUS-1) OR (NOT up AND q = 0)); tc is independent of clr and load.
REQ-021 SHALL assert wrap for exactly one cycle after an edge on which an en-driven wrap (REQ-018/019 boundary case) occurred; never on clr or load.
REQ-022 SHALL keep wrap and load_err low in every cycle not named in REQ-017/021.
REQ-023 SHALL keep q within 0..MODULUS-1 at all times after reset.
REQ-024 SHALL accept a change of up on any cycle; the new direction applies on the next enabled edge, with no extra latency.
REQ-025 SHALL, when MODULUS = 2**WIDTH, behave as a free-running WIDTH-bit binary up/down counter.

Reset
REQ-026 SHALL, while reset is high, force q = 0, wrap = 0, load_err = 0 immediately, independent of clock.
REQ-027 SHALL resume counting on the first rising clock edge after reset deasserts; no edge is lost or doubled.
REQ-028 SHALL let reset asserted mid-operation (including mid-wrap or mid-load) override all pending actions; wrap and load_err SHALL NOT fire after release for pre-reset events.

Structure
REQ-029 SHALL hold q in WIDTH instances of sub-module tff_ar: a toggle flip-flop with async active-high reset, using ports clock, reset, t and q.
REQ-030 SHALL compute next-count combinationally and drive the toggle vector as t = q XOR next_q.
REQ-031 SHALL place direction encodings (DIR_UP = 1, DIR_DOWN = 0) and parameter-range check constants in shared package counter_pkg.
REQ-032 SHALL flag illegal WIDTH/MODULUS at elaboration, not at run time.

Verification (WIDTH=3, MODULUS=6 unless stated)
REQ-033 SHALL cover: reset, then en=1, up=1 for 8 edges -> q = 1,2,3,4,5,0,1,2; tc high while q=5; wrap high one cycle after q 5->0.
REQ-034 SHALL cover: from q=0, en=1, up=0 -> q = 5,4,...; tc high while q=0; wrap pulses once after 0->5.
REQ-035 SHALL cover: load with din=7 -> q = 5, load_err high one cycle; load with din=3 -> q = 3, load_err low.
REQ-036 SHALL cover: clr, load and en all high with din=2 -> q = 0; load and en with din=4 -> q = 4.
REQ-037 SHALL cover: reset asserted between edges while q=5 with en=1 -> q = 0 immediately; no wrap after release.
REQ-038 SHALL cover: WIDTH=4, MODULUS=16, en=1, up=1 for 17 edges -> q wraps 15->0 once; one wrap pulse.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the modulo up/down counter: direction encoding and
// the legal parameter envelope.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam int unsigned WIDTH_MIN   = 1;
  localparam int unsigned WIDTH_MAX   = 16;
  localparam int unsigned MODULUS_MIN = 2;

  function automatic bit params_legal(input int unsigned width, input int unsigned modulus);
    return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
           (modulus >= MODULUS_MIN) && (modulus <= (32'd1 << width));
  endfunction

endpackage

// File: rtl/tff_ar.sv
// Toggle flip-flop with asynchronous active-high reset; one bit of counter state.
module tff_ar (
  input  logic clock,
  input  logic reset,
  input  logic t,
  output logic q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)  q <= 1'b0;
    else if (t) q <= ~q;
  end

endmodule

// File: rtl/mod_counter_tff.sv
// Modulo-MODULUS up/down counter with clear, parallel load, terminal count and
// registered wrap / out-of-range-load pulses; count state lives in toggle flops.
module mod_counter_tff
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned MODULUS = 2**WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  if (!params_legal(WIDTH, MODULUS)) begin : g_bad_params
    $error("mod_counter_tff: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
  end

  localparam logic [WIDTH-1:0] QMAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] next_q;
  logic [WIDTH-1:0] t;
  logic             wrap_d;
  logic             load_err_d;
  dir_e             dir;

  assign dir = dir_e'(up);

  always_comb begin
    next_q     = q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (clr) begin
      next_q = '0;
    end else if (load) begin
      if (32'(din) >= MODULUS) begin
        next_q     = QMAX;
        load_err_d = 1'b1;
      end else begin
        next_q = din;
      end
    end else if (en) begin
      if (dir == DIR_UP) begin
        if (q == QMAX) begin
          next_q = '0;
          wrap_d = 1'b1;
        end else begin
          next_q = q + WIDTH'(1);
        end
      end else begin
        if (q == '0) begin
          next_q = QMAX;
          wrap_d = 1'b1;
        end else begin
          next_q = q - WIDTH'(1);
        end
      end
    end
  end

  // Each flop toggles exactly where the current and next counts differ.
  assign t  = q ^ next_q;
  assign tc = en & (((dir == DIR_UP) & (q == QMAX)) | ((dir == DIR_DOWN) & (q == '0)));

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_ar u_tff (
      .clock (clock),
      .reset (reset),
      .t     (t[i]),
      .q     (q[i])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= wrap_d;
      load_err <= load_err_d;
    end
  end

endmodule

// File: tb/tb_mod_counter_tff.sv
// Scoreboard bench for mod_counter_tff: a 3-bit mod-6 instance and a 4-bit
// free-running instance, each checked against a behavioural model.
module tb_mod_counter_tff;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  logic       a_clr = 0, a_load = 0, a_en = 0, a_up = 0;
  logic [2:0] a_din = '0;
  logic [2:0] a_q;
  logic       a_tc, a_wrap, a_lerr;

  logic       b_clr = 0, b_load = 0, b_en = 0, b_up = 0;
  logic [3:0] b_din = '0;
  logic [3:0] b_q;
  logic       b_tc, b_wrap, b_lerr;

  always #5 clock = ~clock;

  mod_counter_tff #(.WIDTH(3), .MODULUS(6)) dut_a (
    .clock(clock), .reset(reset), .clr(a_clr), .load(a_load), .din(a_din),
    .en(a_en), .up(a_up), .q(a_q), .tc(a_tc), .wrap(a_wrap), .load_err(a_lerr)
  );

  mod_counter_tff #(.WIDTH(4), .MODULUS(16)) dut_b (
    .clock(clock), .reset(reset), .clr(b_clr), .load(b_load), .din(b_din),
    .en(b_en), .up(b_up), .q(b_q), .tc(b_tc), .wrap(b_wrap), .load_err(b_lerr)
  );

  typedef struct {
    int sel;
    int q;
    int wrap;
    int lerr;
  } exp_t;

  exp_t sb[$];
  int   mq[2];
  int   modv[2] = '{6, 16};
  int   n_checks = 0;
  int   n_fail   = 0;
  int   b_wraps  = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int obs_q(input int sel);
    return (sel == 0) ? int'(a_q) : int'(b_q);
  endfunction

  // One clock edge on the selected instance: check tc before the edge,
  // queue the model's prediction, then compare after the edge.
  task automatic step(input int sel, input bit clr, input bit load, input int din,
                      input bit en, input bit up);
    exp_t e;
    int   m;
    int   exp_tc;
    exp_t got;
    m = modv[sel];
    if (sel == 0) begin
      a_clr = clr; a_load = load; a_din = 3'(din); a_en = en; a_up = up;
    end else begin
      b_clr = clr; b_load = load; b_din = 4'(din); b_en = en; b_up = up;
    end
    #1;
    exp_tc = (en && ((up && mq[sel] == m - 1) || (!up && mq[sel] == 0))) ? 1 : 0;
    check_eq("tc", (sel == 0) ? int'(a_tc) : int'(b_tc), exp_tc);

    e.sel = sel; e.q = mq[sel]; e.wrap = 0; e.lerr = 0;
    if (clr) begin
      e.q = 0;
    end else if (load) begin
      if (din >= m) begin e.q = m - 1; e.lerr = 1; end
      else e.q = din;
    end else if (en) begin
      if (up) begin
        e.wrap = (mq[sel] + 1 >= m) ? 1 : 0;
        e.q    = (mq[sel] + 1) % m;
      end else begin
        e.wrap = (mq[sel] == 0) ? 1 : 0;
        e.q    = (mq[sel] + m - 1) % m;
      end
    end
    sb.push_back(e);

    @(posedge clock);
    #1;
    got = sb.pop_front();
    mq[got.sel] = got.q;
    check_eq("q", obs_q(got.sel), got.q);
    check_eq("wrap", (got.sel == 0) ? int'(a_wrap) : int'(b_wrap), got.wrap);
    check_eq("load_err", (got.sel == 0) ? int'(a_lerr) : int'(b_lerr), got.lerr);
    if (got.sel == 1 && b_wrap) b_wraps++;
  endtask

  // Reset raised between edges: outputs must clear without waiting for a clock.
  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    check_eq("rst_q_a", int'(a_q), 0);
    check_eq("rst_wrap_a", int'(a_wrap), 0);
    check_eq("rst_lerr_a", int'(a_lerr), 0);
    check_eq("rst_q_b", int'(b_q), 0);
    #2;
    reset = 1'b0;
    mq[0] = 0;
    mq[1] = 0;
  endtask

  initial begin
    mq[0] = 0;
    mq[1] = 0;
    #2;
    check_eq("init_q", int'(a_q), 0);
    check_eq("init_wrap", int'(a_wrap), 0);
    check_eq("init_lerr", int'(a_lerr), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Count up through the mod-6 wrap: 1,2,3,4,5,0,1,2.
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 1);

    // Clear, then count down through the 0->5 wrap.
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);

    // Hold with no controls.
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);

    // Out-of-range and in-range loads.
    step(0, 0, 1, 7, 0, 1);
    step(0, 0, 1, 3, 0, 1);
    step(0, 0, 1, 6, 1, 0);

    // Priority: clr beats load and en; load beats en.
    step(0, 1, 1, 2, 1, 1);
    step(0, 0, 1, 4, 1, 1);

    // tc ignores clr while at the top of the range; clr suppresses the wrap.
    step(0, 0, 1, 5, 0, 1);
    step(0, 1, 0, 0, 1, 1);

    // Direction change takes effect on the very next enabled edge.
    step(0, 0, 1, 3, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 0);

    // Reset while load_err is high.
    step(0, 0, 1, 7, 0, 1);
    pulse_reset();
    step(0, 0, 0, 0, 0, 1);

    // Reset while wrap is high.
    step(0, 0, 1, 5, 0, 1);
    step(0, 0, 0, 0, 1, 1);
    pulse_reset();
    step(0, 0, 0, 0, 0, 1);

    // Reset between edges at q=5 with en high: no wrap after release.
    step(0, 0, 1, 5, 0, 1);
    a_load = 0; a_en = 1; a_up = 1;
    #1;
    pulse_reset();
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    a_en = 0;

    // 4-bit free-running instance: 17 up edges wrap 15->0 exactly once.
    b_wraps = 0;
    for (int i = 0; i < 17; i++) step(1, 0, 0, 0, 1, 1);
    check_eq("b_wrap_count", b_wraps, 1);
    step(1, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 1, 9, 0, 0);

    check_eq("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
